// File: rtl/score_tracker_pkg.sv
// Shared game constants: state encoding and score limits.
// Imported by the score tracker and its interface users.
package score_tracker_pkg;

  localparam int SCORE_W = 7;
  localparam int MAX_SCORE = 99;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/score_tracker_if.sv
// Game event pulses in, display values out.
// master = game logic side, slave = score tracker.
interface score_tracker_if #(
  parameter int SCORE_W = 7
);

  logic               i_Start;
  logic               i_Point;
  logic               i_Game_Over;
  logic [SCORE_W-1:0] o_Score;
  logic [SCORE_W-1:0] o_High_Score;
  logic               o_Show_High;
  logic               o_New_Record;
  logic               o_Playing;

  modport master (
    output i_Start, i_Point, i_Game_Over,
    input  o_Score, o_High_Score, o_Show_High,
    input  o_New_Record, o_Playing
  );

  modport slave (
    input  i_Start, i_Point, i_Game_Over,
    output o_Score, o_High_Score, o_Show_High,
    output o_New_Record, o_Playing
  );

endinterface

// File: rtl/score_tracker_display_toggle_timer.sv
// Free-running 0..TOGGLE_CLKS-1 counter with clear/enable.
// Emits a one-cycle wrap pulse for blink effects.
module display_toggle_timer #(
  parameter int TOGGLE_CLKS = 12500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Wrap
);

  localparam int CW = (TOGGLE_CLKS > 1) ? $clog2(TOGGLE_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOGGLE_CLKS - 1);

  logic [CW-1:0] cnt;

  assign o_Wrap = i_En && !i_Clr && (cnt == LAST);

  // Count while enabled, wrap at LAST, clear has priority
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clr) begin
      cnt <= '0;
    end else if (i_En) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Game score keeper: saturating score, session high score,
// and final/high alternation after game over.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int MAX_SCORE   = score_tracker_pkg::MAX_SCORE,
  parameter int SCORE_W     = score_tracker_pkg::SCORE_W,
  parameter int TOGGLE_CLKS = 12500000
) (
  input logic            i_Clk,
  input logic            i_Rst,
  score_tracker_if.slave bus
);

  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);

  state_t             state;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high;
  logic [SCORE_W-1:0] disp;
  logic               show_high;
  logic               new_rec;
  logic               playing;

  logic [SCORE_W:0]   inc;
  logic [SCORE_W-1:0] nxt;
  logic               wrap;
  logic               tmr_clr;
  logic               tmr_en;

  assign inc = {1'b0, score} + (SCORE_W+1)'(1);

  // Next score in PLAY: point counted first, held at ceiling
  always_comb begin
    nxt = score;
    if (bus.i_Point && inc <= MAX_EXT) begin
      nxt = inc[SCORE_W-1:0];
    end
  end

  assign tmr_en  = (state == ST_OVER);
  assign tmr_clr = (state != ST_OVER) || bus.i_Start;

  display_toggle_timer #(
    .TOGGLE_CLKS(TOGGLE_CLKS)
  ) u_tmr (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_Clr (tmr_clr),
    .i_En  (tmr_en),
    .o_Wrap(wrap)
  );

  // Game FSM with registered display outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      score     <= '0;
      high      <= '0;
      disp      <= '0;
      show_high <= 1'b1;
      new_rec   <= 1'b0;
      playing   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          disp      <= high;
          show_high <= 1'b1;
          if (bus.i_Start) begin
            state     <= ST_PLAY;
            score     <= '0;
            disp      <= '0;
            show_high <= 1'b0;
            new_rec   <= 1'b0;
            playing   <= 1'b1;
          end
        end
        ST_PLAY: begin
          score <= nxt;
          disp  <= nxt;
          if (bus.i_Game_Over) begin
            state     <= ST_OVER;
            playing   <= 1'b0;
            show_high <= 1'b0;
            if (nxt > high) begin
              high    <= nxt;
              new_rec <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (bus.i_Start) begin
            state     <= ST_PLAY;
            score     <= '0;
            disp      <= '0;
            show_high <= 1'b0;
            new_rec   <= 1'b0;
            playing   <= 1'b1;
          end else if (wrap) begin
            show_high <= !show_high;
            disp      <= show_high ? score : high;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Score      = disp;
  assign bus.o_High_Score = high;
  assign bus.o_Show_High  = show_high;
  assign bus.o_New_Record = new_rec;
  assign bus.o_Playing    = playing;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with a short toggle period.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_score_tracker;

  localparam int SW = 7;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   npass = 0;
  int   ntot = 0;

  score_tracker_if #(.SCORE_W(SW)) bus ();

  score_tracker #(
    .MAX_SCORE  (99),
    .SCORE_W    (SW),
    .TOGGLE_CLKS(TC)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic step(input logic s, input logic p, input logic g);
    bus.i_Start     = s;
    bus.i_Point     = p;
    bus.i_Game_Over = g;
    @(posedge clk);
    #1;
    bus.i_Start     = 1'b0;
    bus.i_Point     = 1'b0;
    bus.i_Game_Over = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic chk_over(input string tag, input int sc, input int sh);
    chk({tag, "_score"}, int'(bus.o_Score), sc);
    chk({tag, "_show"}, int'(bus.o_Show_High), sh);
  endtask

  initial begin
    bus.i_Start     = 1'b0;
    bus.i_Point     = 1'b0;
    bus.i_Game_Over = 1'b0;
    @(posedge clk);
    #1;
    do_rst();
    do_rst();
    chk("rst_score", int'(bus.o_Score), 0);
    chk("rst_high", int'(bus.o_High_Score), 0);
    chk("rst_show", int'(bus.o_Show_High), 1);
    chk("rst_rec", int'(bus.o_New_Record), 0);
    chk("rst_play", int'(bus.o_Playing), 0);

    // Game 1: five points
    step(1, 0, 0);
    chk("g1_start", int'(bus.o_Score), 0);
    chk("g1_play", int'(bus.o_Playing), 1);
    chk("g1_show", int'(bus.o_Show_High), 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0);
      chk("g1_pt", int'(bus.o_Score), k);
    end
    step(0, 0, 1);
    chk("g1_over_score", int'(bus.o_Score), 5);
    chk("g1_high", int'(bus.o_High_Score), 5);
    chk("g1_rec", int'(bus.o_New_Record), 1);
    chk("g1_play0", int'(bus.o_Playing), 0);
    chk("g1_show0", int'(bus.o_Show_High), 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      chk_over("g1_ph0", 5, 0);
    end
    step(0, 0, 0);
    chk_over("g1_ph1", 5, 1);

    // Game 2: three points, alternation 3/5
    step(1, 0, 0);
    chk("g2_start", int'(bus.o_Score), 0);
    chk("g2_rec_clr", int'(bus.o_New_Record), 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 0);
      chk("g2_pt", int'(bus.o_Score), k);
    end
    step(0, 0, 1);
    chk("g2_high", int'(bus.o_High_Score), 5);
    chk("g2_rec", int'(bus.o_New_Record), 0);
    chk_over("g2_a", 3, 0);
    idle(3);
    chk_over("g2_b", 3, 0);
    step(0, 0, 0);
    chk_over("g2_c", 5, 1);
    idle(3);
    chk_over("g2_d", 5, 1);
    step(0, 0, 0);
    chk_over("g2_e", 3, 0);

    // Tie game: 5 points is not a record
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0);
    step(0, 0, 1);
    chk("tie_score", int'(bus.o_Score), 5);
    chk("tie_high", int'(bus.o_High_Score), 5);
    chk("tie_rec", int'(bus.o_New_Record), 0);

    // Saturation at 99
    step(1, 0, 0);
    for (int k = 1; k <= 105; k++) begin
      step(0, 1, 0);
      if (k == 99) chk("sat_99", int'(bus.o_Score), 99);
    end
    chk("sat_hold", int'(bus.o_Score), 99);
    step(0, 0, 1);
    chk("sat_high", int'(bus.o_High_Score), 99);
    chk("sat_rec", int'(bus.o_New_Record), 1);

    // High 7, then point+game-over from 7
    do_rst();
    step(1, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 1, 0);
    step(0, 0, 1);
    chk("h7_high", int'(bus.o_High_Score), 7);
    step(1, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 1, 0);
    chk("h7_score", int'(bus.o_Score), 7);
    chk("h7_norec", int'(bus.o_New_Record), 0);
    step(0, 1, 1);
    chk("pg_score", int'(bus.o_Score), 8);
    chk("pg_high", int'(bus.o_High_Score), 8);
    chk("pg_rec", int'(bus.o_New_Record), 1);
    chk("pg_play", int'(bus.o_Playing), 0);

    // Start + game over together: game over wins
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    chk("sg_play", int'(bus.o_Playing), 0);
    chk("sg_score", int'(bus.o_Score), 1);
    chk("sg_high", int'(bus.o_High_Score), 8);

    // Start ignored in PLAY, reset mid-game at 12
    step(1, 0, 0);
    for (int k = 0; k < 12; k++) step(0, 1, 0);
    step(1, 0, 0);
    chk("ps_score", int'(bus.o_Score), 12);
    chk("ps_play", int'(bus.o_Playing), 1);
    do_rst();
    chk("mr_score", int'(bus.o_Score), 0);
    chk("mr_high", int'(bus.o_High_Score), 0);
    chk("mr_play", int'(bus.o_Playing), 0);
    chk("mr_show", int'(bus.o_Show_High), 1);

    // Point and game over ignored in IDLE
    step(0, 1, 1);
    step(0, 1, 0);
    chk("idl_score", int'(bus.o_Score), 0);
    chk("idl_play", int'(bus.o_Playing), 0);
    chk("idl_show", int'(bus.o_Show_High), 1);
    chk("idl_high", int'(bus.o_High_Score), 0);
    step(1, 0, 0);
    chk("idl_start", int'(bus.o_Playing), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
